// File: rtl/execute_writeback.sv
// Two-entry in-order write-back buffer between execute and the register-file write port,
// with a forwarding lookup over entries still pending write-back.
module execute_writeback #(
    parameter int LEN_REG   = 32,
    parameter int LEN_REGNO = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_wen,
    input  logic [LEN_REGNO-1:0] in_rd,
    input  logic [LEN_REG-1:0]   in_data,
    output logic                 rf_we,
    output logic [LEN_REGNO-1:0] rf_waddr,
    output logic [LEN_REG-1:0]   rf_wdata,
    input  logic                 rf_ready,
    input  logic [LEN_REGNO-1:0] fwd_addr,
    output logic                 fwd_hit,
    output logic [LEN_REG-1:0]   fwd_data,
    output logic [1:0]           count
);

    logic [LEN_REGNO-1:0] rd_q   [2];
    logic [LEN_REG-1:0]   data_q [2];
    logic                 head;
    logic                 tail;
    logic [1:0]           count_q;
    logic                 push;
    logic                 pop;
    logic                 young;

    assign in_ready = (count_q != 2'd2);
    assign rf_we    = (count_q != 2'd0);
    assign push     = in_valid && in_ready && in_wen;
    assign pop      = rf_we && rf_ready;
    assign count    = count_q;
    assign young    = ~tail;

    always_comb begin
        rf_waddr = '0;
        rf_wdata = '0;
        if (rf_we) begin
            rf_waddr = rd_q[head];
            rf_wdata = data_q[head];
        end
    end

    // The entry just behind tail is the youngest; when only one entry is held it is also head.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (count_q != 2'd0 && rd_q[young] == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[young];
        end else if (count_q == 2'd2 && rd_q[head] == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[head];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= 1'b0;
            tail    <= 1'b0;
            count_q <= '0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail]   <= in_rd;
            data_q[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_execute_writeback.sv
// Directed and randomized checks of execute_writeback against a queue-based reference model.
module tb_execute_writeback;

    localparam int LEN_REG   = 32;
    localparam int LEN_REGNO = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_wen;
    logic [LEN_REGNO-1:0] in_rd;
    logic [LEN_REG-1:0]   in_data;
    logic                 rf_we;
    logic [LEN_REGNO-1:0] rf_waddr;
    logic [LEN_REG-1:0]   rf_wdata;
    logic                 rf_ready;
    logic [LEN_REGNO-1:0] fwd_addr;
    logic                 fwd_hit;
    logic [LEN_REG-1:0]   fwd_data;
    logic [1:0]           count;

    typedef struct packed {
        logic [LEN_REGNO-1:0] rd;
        logic [LEN_REG-1:0]   data;
    } entry_t;

    entry_t q[$];
    int vectors     = 0;
    int miscompares = 0;

    execute_writeback #(.LEN_REG(LEN_REG), .LEN_REGNO(LEN_REGNO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_wen   (in_wen),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_ready (rf_ready),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs straight from the queue: front is next to write, back is youngest.
    task automatic check_all(input string ctx);
        logic                 exp_hit;
        logic [LEN_REG-1:0]   exp_fdata;
        logic [LEN_REGNO-1:0] exp_waddr;
        logic [LEN_REG-1:0]   exp_wdata;
        exp_hit   = 1'b0;
        exp_fdata = '0;
        exp_waddr = '0;
        exp_wdata = '0;
        if (q.size() != 0) begin
            exp_waddr = q[0].rd;
            exp_wdata = q[0].data;
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!exp_hit && q[i].rd == fwd_addr) begin
                exp_hit   = 1'b1;
                exp_fdata = q[i].data;
            end
        end
        check({ctx, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        check({ctx, ".rf_we"},    64'(rf_we),    64'(q.size() != 0));
        check({ctx, ".rf_waddr"}, 64'(rf_waddr), 64'(exp_waddr));
        check({ctx, ".rf_wdata"}, 64'(rf_wdata), 64'(exp_wdata));
        check({ctx, ".fwd_hit"},  64'(fwd_hit),  64'(exp_hit));
        check({ctx, ".fwd_data"}, 64'(fwd_data), 64'(exp_fdata));
        check({ctx, ".count"},    64'(count),    64'(q.size()));
    endtask

    // Entered just after a falling edge; returns just after the next falling edge.
    task automatic step(input string ctx, input logic v, input logic wen,
                        input logic [LEN_REGNO-1:0] rd, input logic [LEN_REG-1:0] data,
                        input logic rfr, input logic [LEN_REGNO-1:0] faddr);
        logic accept;
        logic drain;
        in_valid = v;
        in_wen   = wen;
        in_rd    = rd;
        in_data  = data;
        rf_ready = rfr;
        fwd_addr = faddr;
        #1;
        check_all(ctx);
        accept = v && (q.size() < 2);
        drain  = (q.size() != 0) && rfr;
        if (drain) void'(q.pop_front());
        if (accept && wen) q.push_back('{rd: rd, data: data});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_wen   = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        rf_ready = 1'b0;
        fwd_addr = '0;
        @(negedge clk);
        #1;
        check("reset.in_ready", 64'(in_ready), 64'(1));
        check("reset.rf_we",    64'(rf_we),    64'(0));
        check("reset.fwd_hit",  64'(fwd_hit),  64'(0));
        check("reset.count",    64'(count),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        step("single.push", 1, 1, 4'd3, 32'hDEADBEEF, 1, 4'd3);
        step("single.out",  0, 0, 4'd0, 32'h0,        1, 4'd3);
        step("single.done", 0, 0, 4'd0, 32'h0,        1, 4'd3);

        step("fill.p1",   1, 1, 4'd1, 32'h11, 0, 4'd1);
        step("fill.p2",   1, 1, 4'd2, 32'h22, 0, 4'd2);
        step("fill.p3",   1, 1, 4'd7, 32'h33, 0, 4'd1);
        step("fill.hold", 1, 1, 4'd7, 32'h33, 0, 4'd2);
        step("fill.d1",   0, 0, 4'd0, 32'h0,  1, 4'd2);
        step("fill.d2",   0, 0, 4'd0, 32'h0,  1, 4'd2);
        step("fill.idle", 0, 0, 4'd0, 32'h0,  1, 4'd2);

        step("discard.a", 1, 0, 4'd4, 32'h55, 1, 4'd4);
        step("discard.b", 1, 0, 4'd4, 32'h66, 1, 4'd4);
        step("discard.c", 0, 0, 4'd0, 32'h0,  1, 4'd4);

        step("fwd.p1",   1, 1, 4'd5, 32'hA, 0, 4'd5);
        step("fwd.p2",   1, 1, 4'd5, 32'hB, 0, 4'd5);
        step("fwd.hit",  0, 0, 4'd0, 32'h0, 0, 4'd5);
        step("fwd.miss", 0, 0, 4'd0, 32'h0, 0, 4'd6);
        step("fwd.d1",   0, 0, 4'd0, 32'h0, 1, 4'd5);
        step("fwd.d2",   0, 0, 4'd0, 32'h0, 1, 4'd5);

        for (int i = 0; i < 8; i++)
            step("stream", 1, 1, 4'(i), 32'(i), 1, 4'(i));
        step("stream.end",  0, 0, 4'd0, 32'h0, 1, 4'd0);
        step("stream.idle", 0, 0, 4'd0, 32'h0, 1, 4'd0);

        step("rstmid.p1", 1, 1, 4'd9,  32'h99, 0, 4'd9);
        step("rstmid.p2", 1, 1, 4'd10, 32'hAA, 0, 4'd9);
        in_valid = 1'b0;
        #1;
        check("rstmid.full", 64'(count), 64'(q.size()));
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("rstmid.rf_we",    64'(rf_we),    64'(0));
        check("rstmid.fwd_hit",  64'(fwd_hit),  64'(0));
        check("rstmid.count",    64'(count),    64'(0));
        check("rstmid.in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step("rstmid.after", 1, 1, 4'd12, 32'hC0FFEE, 0, 4'd12);
        step("rstmid.out",   0, 0, 4'd0,  32'h0,      1, 4'd12);
        step("rstmid.idle",  0, 0, 4'd0,  32'h0,      1, 4'd12);

        for (int i = 0; i < 300; i++) begin
            step("random",
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 3)),
                 32'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 4'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
